// File: rtl/divider_r2.sv
// -----------------------------------------------------------------------------
// divider_r2
//   Iterative 32-bit radix-2 restoring divider for a CPU multiply/divide unit.
//   Supports signed (DIV) and unsigned (DIVU) operation. One quotient bit is
//   produced per cycle, so a result takes 32 cycles after acceptance. A zero
//   divisor short-circuits straight to DONE with an all-zero result.
//
// Ports
//   clk         in   1   rising-edge clock for all state
//   rst         in   1   synchronous active-high reset
//   div_start   in   1   request, held high upstream until div_ready is seen
//   div_signed  in   1   1 = signed, 0 = unsigned; sampled on acceptance
//   div_annul   in   1   abort request (pipeline flush); overrides div_start
//   div_a       in  32   dividend; sampled on acceptance
//   div_b       in  32   divisor; sampled on acceptance
//   div_result  out 64   {remainder (HI), quotient (LO)}; zero outside DONE
//   div_ready   out  1   result valid; high only in DONE
// -----------------------------------------------------------------------------
module divider_r2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic        div_annul,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  output logic [63:0] div_result,
  output logic        div_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    logic [31:0] res;
    if (en) begin
      res = 32'd0 - v;
    end else begin
      res = v;
    end
    return res;
  endfunction

  state_t      r_state;
  logic [5:0]  r_cnt;      // steps completed in the current operation
  logic [31:0] r_quo;      // dividend shifts out of the top, quotient bits in at the bottom
  logic [31:0] r_dvs;      // magnitude of the divisor
  logic [31:0] r_rem;      // partial remainder
  logic        r_neg_q;    // quotient needs negation at the end
  logic        r_neg_r;    // remainder needs negation at the end
  logic [63:0] r_result;
  logic        r_ready;

  // Operand magnitudes and sign bookkeeping, evaluated at acceptance.
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic        w_neg_q;
  logic        w_neg_r;

  assign w_abs_a = neg_if(div_signed & div_a[31], div_a);
  assign w_abs_b = neg_if(div_signed & div_b[31], div_b);
  assign w_neg_q = div_signed & (div_a[31] ^ div_b[31]);
  assign w_neg_r = div_signed & div_a[31];

  // One restoring step. The shifted remainder is 33 bits wide; because the
  // remainder stays below the divisor, bit 32 of the difference is a clean
  // borrow flag (set means the trial subtraction must be undone).
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  assign w_rem_sh  = {r_rem, r_quo[31]};
  assign w_diff    = w_rem_sh - {1'b0, r_dvs};
  assign w_fits    = ~w_diff[32];
  assign w_rem_nxt = w_fits ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_fits};

  // Sign fix-up applied to the values produced by the final step. The
  // 0x80000000 / -1 case wraps naturally: |a| stays 0x80000000 and no
  // negation is applied because both operand signs match.
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_q_fix = neg_if(r_neg_q, w_quo_nxt);
  assign w_r_fix = neg_if(r_neg_r, w_rem_nxt);

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_quo    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 64'd0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_result <= 64'd0;
          r_cnt    <= 6'd0;
          if (div_start && !div_annul) begin
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= 32'd0;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            if (w_abs_b == 32'd0) begin
              // Divide by zero: report an all-zero result immediately.
              r_state <= S_DONE;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_BUSY;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_BUSY: begin
          // Abort wins even on the edge that would complete the last step.
          if (div_annul || !div_start) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_ready  <= 1'b0;
            r_result <= 64'd0;
          end else begin
            r_quo <= w_quo_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_state  <= S_DONE;
              r_ready  <= 1'b1;
              r_result <= {w_r_fix, w_q_fix};
            end else begin
              r_state <= S_BUSY;
            end
          end
        end

        S_DONE: begin
          // Leaving DONE always passes through IDLE, so a new request
          // cannot be accepted back-to-back.
          if (div_annul || !div_start) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_ready  <= 1'b0;
            r_result <= 64'd0;
          end else begin
            r_state <= S_DONE;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= 6'd0;
          r_ready  <= 1'b0;
          r_result <= 64'd0;
        end
      endcase
    end
  end

  assign div_result = r_result;
  assign div_ready  = r_ready;

endmodule

// File: tb/tb_divider_r2.sv
// -----------------------------------------------------------------------------
// tb_divider_r2
//   Directed bench for divider_r2. Stimulus pushes the hand-computed result and
//   the cycle in which div_ready must first rise into a queue; an independent
//   monitor pops an entry on every rising div_ready and compares. Control-path
//   behaviour (reset, abort, DONE hold/clear) is checked inline by stimulus.
// -----------------------------------------------------------------------------
module tb_divider_r2;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        div_ready;

  divider_r2 dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_annul  (div_annul),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .div_ready  (div_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every rising div_ready must match the oldest expected entry.
  initial begin
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (div_ready === 1'b1 && prev_ready !== 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ready: actual ready=1 at cycle %0d required no ready", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", div_result, e.res);
          chk("ready_cycle", 64'(cyc), 64'(e.at_cyc));
        end
      end
      prev_ready = div_ready;
    end
  end

  // Present a request; returns after the acceptance edge with its cycle number.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, output int acc);
    @(negedge clk);
    div_a      = a;
    div_b      = b;
    div_signed = s;
    div_annul  = 1'b0;
    div_start  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic expect_res(input logic [63:0] res, input int at);
    exp_t e;
    e.res    = res;
    e.at_cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (div_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (div_ready !== 1'b1) begin
      n_total++;
      $display("FAIL ready_timeout: actual ready=%b required ready=1 within 40 cycles", div_ready);
    end
  endtask

  // Drop start and check the outputs clear on the next edge.
  task automatic release_op(input string name);
    @(negedge clk);
    div_start = 1'b0;
    div_annul = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_ready"}, {63'd0, div_ready}, 64'd0);
    chk({name, "_result"}, div_result, 64'd0);
  endtask

  initial begin
    int acc;
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_annul  = 1'b0;
    div_a      = 32'd0;
    div_b      = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, div_ready}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7 unsigned, then hold start in DONE for 5 cycles.
    issue(32'd100, 32'd7, 1'b0, acc);
    expect_res({32'd2, 32'd14}, acc + 32);
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      div_a = 32'hDEAD_0000 + 32'(i);
      chk("hold_ready", {63'd0, div_ready}, 64'd1);
      chk("hold_result", div_result, {32'd2, 32'd14});
    end
    release_op("done_clear");

    // -7 / 2 signed, then annul while in DONE.
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    expect_res({32'hFFFF_FFFF, 32'hFFFF_FFFD}, acc + 32);
    wait_ready();
    @(negedge clk);
    div_annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_done_ready", {63'd0, div_ready}, 64'd0);
    chk("annul_done_result", div_result, 64'd0);
    @(negedge clk);
    div_annul = 1'b0;
    div_start = 1'b0;

    // Signed overflow wraps.
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    expect_res({32'h0000_0000, 32'h8000_0000}, acc + 32);
    wait_ready();
    release_op("ovf_clear");

    // 100 / -7 signed: quotient negative, remainder positive.
    issue(32'd100, 32'hFFFF_FFF9, 1'b1, acc);
    expect_res({32'd2, 32'hFFFF_FFF2}, acc + 32);
    wait_ready();
    release_op("mixed_clear");

    // Divide by zero: ready in the first cycle after acceptance.
    issue(32'd5, 32'd0, 1'b0, acc);
    expect_res(64'd0, acc);
    wait_ready();
    release_op("div0_clear");

    // Annul at BUSY step 10, then a fresh request.
    issue(32'd50, 32'd3, 1'b0, acc);
    repeat (9) @(posedge clk);
    #1;
    div_annul = 1'b1;
    @(posedge clk);
    #1;
    chk("annul_busy_ready", {63'd0, div_ready}, 64'd0);
    chk("annul_busy_result", div_result, 64'd0);
    @(negedge clk);
    div_annul = 1'b0;
    div_start = 1'b0;
    repeat (2) @(posedge clk);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, acc);
    expect_res({32'd0, 32'hFFFF_FFFF}, acc + 32);
    wait_ready();
    release_op("fresh_clear");

    // Reset at BUSY step 20.
    issue(32'd1000, 32'd3, 1'b0, acc);
    repeat (19) @(posedge clk);
    #1;
    rst       = 1'b1;
    div_start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy_ready", {63'd0, div_ready}, 64'd0);
    chk("rst_busy_result", div_result, 64'd0);
    rst = 1'b0;

    // Start dropped so the abort lands on the 32nd-step edge.
    issue(32'd77, 32'd5, 1'b0, acc);
    repeat (31) @(posedge clk);
    #1;
    div_start = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_last_ready", {63'd0, div_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_last_later", {63'd0, div_ready}, 64'd0);

    // Operands change during BUSY; result must follow the latched values.
    issue(32'd1000, 32'd10, 1'b0, acc);
    expect_res({32'd0, 32'd100}, acc + 32);
    repeat (5) @(posedge clk);
    #1;
    div_a      = 32'd12345;
    div_b      = 32'd0;
    div_signed = 1'b1;
    wait_ready();
    release_op("opchg_clear");

    // start with annul in IDLE is not accepted; acceptance waits for annul=0.
    @(negedge clk);
    div_a      = 32'd20;
    div_b      = 32'd6;
    div_signed = 1'b0;
    div_start  = 1'b1;
    div_annul  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_annul_ready", {63'd0, div_ready}, 64'd0);
    @(negedge clk);
    div_annul = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    expect_res({32'd2, 32'd3}, acc + 32);
    wait_ready();
    release_op("late_accept_clear");

    // Dividend smaller than divisor.
    issue(32'd7, 32'd100, 1'b0, acc);
    expect_res({32'd7, 32'd0}, acc + 32);
    wait_ready();
    release_op("small_clear");

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divider_r2.md
DIVIDER_R2 -- requirements
Module: divider_r2

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 div_start  in  1  request; held high by the upstream decoder until div_ready is seen.
REQ-005 div_signed  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
REQ-006 div_annul  in  1  abort request (pipeline flush); overrides div_start.
REQ-007 div_a  in  32  dividend; sampled on acceptance.
REQ-008 div_b  in  32  divisor; sampled on acceptance.
REQ-009 div_result  out  64  {remainder[63:32] (HI), quotient[31:0] (LO)}, registered.
REQ-010 div_ready  out  1  result valid, registered.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-012 Acceptance: in IDLE, a rising edge with div_start=1 and div_annul=0 SHALL latch div_a, div_b and div_signed; later operand changes have no effect.
REQ-013 If div_start=1 and div_annul=1 in IDLE, the block SHALL NOT accept and SHALL remain in IDLE.
REQ-014 If the latched divisor is 0, the block SHALL go IDLE->DONE on the acceptance edge with div_result=64'h0.
REQ-015 Otherwise IDLE->BUSY; in BUSY a 6-bit counter SHALL perform one restoring shift-subtract step per cycle, 32 steps total.
REQ-016 In signed mode, the operands SHALL be replaced by their absolute values at acceptance (two's-complement negate if bit 31 = 1).
REQ-017 After the 32nd step, the block SHALL move to DONE and load div_result.
REQ-018 Sign fix-up: the quotient SHALL be negated iff signed and the operand signs differ; the remainder SHALL be negated iff signed and the dividend is negative.
REQ-019 Overflow case: signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (natural 32-bit wrap, no trap).
REQ-020 Latency: div_ready SHALL be high in the 33rd cycle after the acceptance edge (divisor != 0), or in the 1st cycle after it (divisor = 0).
REQ-021 div_ready SHALL be 1 only in DONE; div_result SHALL be 64'h0 in every state other than DONE.
REQ-022 In DONE, the block SHALL hold div_ready=1 and div_result stable while div_start=1 and div_annul=0.
REQ-023 In DONE, div_start=0 SHALL move the block to IDLE on the next edge, with div_ready=0 and div_result=0.
REQ-024 A new request SHALL need at least one IDLE cycle; back-to-back acceptance directly from DONE is not allowed.
REQ-025 In BUSY, div_annul=1 or div_start=0 SHALL abort: next state IDLE, counter cleared, div_ready never asserted for that operation.
REQ-026 In DONE, div_annul=1 SHALL move the block to IDLE on the next edge, with div_result cleared.
REQ-027 If abort and the last step fall on the same edge, the abort SHALL take priority: go to IDLE with no ready.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE, counter=0, div_ready=0, div_result=64'h0 and clear the latched operands, in any state including mid-BUSY.
REQ-029 rst SHALL take priority over div_start and div_annul on the same edge.

Verification
REQ-030 Unsigned: div_a=100, div_b=7, div_signed=0, start held -> div_ready=1 in cycle 33 after acceptance, div_result={32'd2, 32'd14}.
REQ-031 Signed: div_a=0xFFFFFFF9 (-7), div_b=2, div_signed=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-032 Divide by zero: div_a=5, div_b=0 -> div_ready=1 one cycle after acceptance, div_result=0; drop start -> IDLE next cycle.
REQ-033 Annul at BUSY step 10 -> IDLE next cycle, div_ready stays 0; a fresh request 0xFFFFFFFF/1 unsigned -> {0, 0xFFFFFFFF} after 33 cycles.
REQ-034 rst pulsed at BUSY step 20 -> all outputs 0 next cycle; simultaneous abort and 32nd step -> no ready pulse.
REQ-035 Operands changed during BUSY -> result unchanged; in DONE with start held for 5 cycles -> div_ready and div_result constant, then start=0 -> both cleared next cycle.
